// File: rtl/gray_pkg.sv
// gray_pkg: shared types, default sizes and Gray/binary helpers for the
// Gray-code tracker.
//   state_t          : tracker FSM states (INIT, TRACK, ERROR)
//   DEF_*            : default parameter values
//   gray2bin/bin2gray: 32-bit helpers. Upper bits must be zero for narrower
//                      counts, which makes them correct for any WIDTH <= 32.
package gray_pkg;

    localparam int DEF_WIDTH       = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_WRAP_W      = 8;
    localparam int ERR_CNT_W       = 8;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    // Prefix XOR from the MSB down.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary decode.
//   gray : WIDTH-bit Gray-coded input
//   bin  : WIDTH-bit binary result, bin[MSB]=gray[MSB], bin[i]=bin[i+1]^gray[i]
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_tracker.sv
// gray_tracker: receive side of a Gray-code counter link.
// Synchronizes an asynchronous Gray count, decodes it to binary and checks
// that every observed change is exactly one +1 step (mod 2^WIDTH).
//
// Ports:
//   Clk, Reset  : clock, synchronous active-high reset
//   GrayIn      : Gray count from another clock domain
//   Clear       : leaves ERROR / forces a resync; clears Error and WrapCount
//   BinOut      : tracked binary count
//   Step, Wrap  : registered one-cycle pulses (advance by 1, advance 7->0 style)
//   WrapCount   : number of wraps modulo 2^WRAP_W
//   Locked      : high while in TRACK
//   Error       : sticky illegal-transition flag
//   DbgState    : current FSM state for observation
//   ErrCount, LastBad : only when GRAY_ERR_CNT_EN is defined; saturating
//                       illegal-transition count and the decoded value that
//                       caused the most recent one.
//
// Handshake: there is none; GrayIn is sampled every cycle and all outputs are
// valid every cycle after reset.
module gray_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int WRAP_W      = DEF_WRAP_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  GrayIn,
    input  logic              Clear,
    output logic [WIDTH-1:0]  BinOut,
    output logic              Step,
    output logic              Wrap,
    output logic [WRAP_W-1:0] WrapCount,
    output logic              Locked,
    output logic              Error,
`ifdef GRAY_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] ErrCount,
    output logic [WIDTH-1:0]     LastBad,
`endif
    output state_t            DbgState
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES);

    // Synchronizer chain; stage SYNC_STAGES-1 is the settled sample.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] dec;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= GrayIn;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (sync_q[SYNC_STAGES-1]),
        .bin  (dec)
    );

    state_t            state_q, state_n;
    logic [FILL_W-1:0] fill_q, fill_n;
    logic [WIDTH-1:0]  bin_q, bin_n;
    logic              step_q, step_n;
    logic              wrap_q, wrap_n;
    logic [WRAP_W-1:0] wcnt_q, wcnt_n;
    logic              err_q, err_n;
    logic              illegal;
    logic [WIDTH-1:0]  delta;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INIT;
            fill_q  <= '0;
            bin_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            fill_q  <= fill_n;
            bin_q   <= bin_n;
            step_q  <= step_n;
            wrap_q  <= wrap_n;
            wcnt_q  <= wcnt_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        fill_n  = fill_q;
        bin_n   = bin_q;
        step_n  = 1'b0;
        wrap_n  = 1'b0;
        wcnt_n  = wcnt_q;
        err_n   = err_q;
        illegal = 1'b0;
        // Forward distance mod 2^WIDTH: 1 is the only legal change.
        delta   = dec - bin_q;

        if (Clear) begin
            // The chain is already full, so capture happens on the next edge.
            state_n = INIT;
            fill_n  = FILL_FULL;
            err_n   = 1'b0;
            wcnt_n  = '0;
        end else begin
            unique case (state_q)
                INIT: begin
                    if (fill_q == FILL_FULL) begin
                        bin_n   = dec;
                        state_n = TRACK;
                    end else begin
                        fill_n = fill_q + 1'b1;
                    end
                end
                TRACK: begin
                    if (delta == WIDTH'(1)) begin
                        bin_n  = dec;
                        step_n = 1'b1;
                        if (dec == '0) begin
                            wrap_n = 1'b1;
                            wcnt_n = wcnt_q + 1'b1;
                        end
                    end else if (delta != '0) begin
                        illegal = 1'b1;
                        err_n   = 1'b1;
                        state_n = ERROR;
                    end
                end
                ERROR: begin
                end
                default: begin
                    state_n = INIT;
                end
            endcase
        end
    end

`ifdef GRAY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] ecnt_q;
    logic [WIDTH-1:0]     bad_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ecnt_q <= '0;
            bad_q  <= '0;
        end else if (Clear) begin
            ecnt_q <= '0;
        end else if (illegal) begin
            if (ecnt_q != '1) ecnt_q <= ecnt_q + 1'b1;
            bad_q <= dec;
        end
    end

    assign ErrCount = ecnt_q;
    assign LastBad  = bad_q;
`endif

    assign BinOut    = bin_q;
    assign Step      = step_q;
    assign Wrap      = wrap_q;
    assign WrapCount = wcnt_q;
    assign Error     = err_q;
    assign Locked    = (state_q == TRACK);
    assign DbgState  = state_q;

endmodule

// File: doc/gray_tracker.md
Name: gray_tracker

Overview:
Receive-side companion to the team's Gray-code counter. Samples an asynchronous WIDTH-bit Gray-coded count through a synchronizer chain and converts it to binary. Verifies that each change is a legal single +1 step and reports steps, wrap-arounds and illegal jumps. Sits at the consuming end of any Gray-counter link, for example cross-domain pointers or position encoders.

Parameters:
WIDTH, 3, Gray/binary count width (>=2)
SYNC_STAGES, 2, synchronizer flops on GrayIn (>=2)
WRAP_W, 8, width of wrap counter

Ports:
Clk  in  1  clock
Reset  in  1  reset Reset, synchronous, active-high; clock Clk
GrayIn  in  WIDTH  Gray-coded count, asynchronous to Clk
Clear  in  1  leave ERROR/resync; clears Error and WrapCount
BinOut  out  WIDTH  tracked binary count
Step  out  1  one-cycle pulse: BinOut advanced by 1
Wrap  out  1  one-cycle pulse: advance from 2^WIDTH-1 to 0
WrapCount  out  WRAP_W  number of wraps, modulo 2^WRAP_W
Locked  out  1  high in TRACK state
Error  out  1  sticky: illegal transition detected

Behaviour:
- Reset (all outputs and registers): sync chain=0, BinOut=0, Step=0, Wrap=0, WrapCount=0, Error=0, Locked=0, state=INIT, fill counter=0.
- Sync chain: GrayIn enters stage 1 each edge; the last stage is S.
- Decode: dec = Gray-to-binary(S); dec[WIDTH-1]=S[WIDTH-1], dec[i]=dec[i+1]^S[i].
- Latency: a stable GrayIn change appears on BinOut SYNC_STAGES+1 edges later.
- States: INIT, TRACK, ERROR.
- INIT:
  - Fill counter increments each cycle.
  - Once the counter reaches SYNC_STAGES, the next edge loads BinOut<=dec and moves to TRACK.
  - No Step/Wrap pulse on this capture.
- TRACK (Locked=1). Compute d = dec - BinOut mod 2^WIDTH:
  - d==0: hold; Step=0.
  - d==1: BinOut<=dec, Step=1. If BinOut was 2^WIDTH-1 (dec==0): also Wrap=1 and WrapCount<=WrapCount+1, wrapping to 0 at 2^WRAP_W-1.
  - Any other d: Error<=1, state<=ERROR, BinOut holds, Step=0, Wrap=0.
- ERROR:
  - BinOut frozen; Step=0, Wrap=0; Locked=0; Error remains 1.
- Clear (any state):
  - Next edge: Error=0, WrapCount=0, state=INIT, fill counter=SYNC_STAGES (chain already full), so capture occurs on the following edge.
  - Step/Wrap forced 0 that cycle.
- Priority: Reset > Clear > normal operation.
- Reset mid-operation: reset values restored on the same edge; the INIT fill restarts from 0.
- Step and Wrap are registered and last exactly one cycle each.

Optional Feature:
GRAY_ERR_CNT_EN
- Defined:
  - Adds output ErrCount[7:0], reset 0.
  - Increments, saturating at 255, on each illegal transition detected in TRACK.
  - Cleared by Clear.
  - Also adds output LastBad[WIDTH-1:0] = the dec value that caused the most recent error, reset 0.
- Undefined: neither port nor logic exists; behaviour otherwise identical.

Decomposition:
- Package gray_pkg:
  - state enum (INIT, TRACK, ERROR);
  - default width constants;
  - Gray-to-binary and binary-to-Gray functions, which the bench reuses for its reference model.
- Sub-module gray_to_bin: combinational, parameter WIDTH, the XOR-prefix decode; one instance on S.
- Synchronizer chain and FSM stay in gray_tracker.

Test Plan:
- Lock: WIDTH=3, SYNC_STAGES=2. Reset, GrayIn=3'b011 held -> BinOut=2 and Locked=1 after fill + capture, with no Step pulse.
- Count: feed Gray 011,010,110,111,101,100 one per 4 cycles -> BinOut 3,4,5,6,7 each Step pulse exactly once; no Error.
- Wrap: from Gray 100 (bin 7) drive 000 -> BinOut=0, Step=1 and Wrap=1 same cycle, WrapCount=1; repeat 256 wraps with WRAP_W=8 -> WrapCount returns to 0.
- Illegal: locked at bin 1 (Gray 001), drive 110 (bin 4) -> Error=1, Locked=0, BinOut stays 1. With GRAY_ERR_CNT_EN: ErrCount=1, LastBad=4.
- Recover: in ERROR, pulse Clear with GrayIn=110 -> Error=0, WrapCount=0, BinOut=4 two edges later, Locked=1, no Step.
- Reset vs Clear: assert Reset and Clear together mid-count -> all reset values, state INIT, full fill delay before next capture.
